// File: rtl/fp_mul_arb_pkg.sv
// fp_mul_arb_pkg: shared constants, tag-width rule and round-robin pick for fp_mul_arbiter
package fp_mul_arb_pkg;
  localparam int FP_W = 32;
  localparam logic [7:0] EXP_BIAS = 8'd127;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0;
  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Returns {found, index}; scanning from the top offset down leaves the nearest hit to ptr.
  function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
    logic [3:0] r;
    int j;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (k < n && valid[3'(j)]) r = {1'b1, 3'(j)};
    end
    return r;
  endfunction
endpackage

// File: rtl/mul_fp_single.sv
// mul_fp_single: truncating single-precision multiply with zero detect, no NaN/Inf handling
module mul_fp_single
  import fp_mul_arb_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] out
);
  logic [24:0] ph;
  logic [7:0]  e;
  logic [22:0] m;
  always_comb begin
    ph  = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
    m   = ph[24] ? ph[23:1] : ph[22:0];
    e   = a[30:23] + b[30:23] - EXP_BIAS + {7'd0, ph[24]};
    out = (a == FP_ZERO || b == FP_ZERO) ? FP_ZERO : {a[31] ^ b[31], e, m};
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one mul_fp_single among NREQ requesters
// Define FP_MUL_ARB_OUTREG_EN to register the multiplier output (latency 2 instead of 1).
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [FP_W*NREQ-1:0] req_a,
  input  logic [FP_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [FP_W-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);
  logic [IDW-1:0]  ptr_q, ptr_d, s1_id_q, s1_id_d;
  logic            s1_valid_q, s1_valid_d, s1_adv, xfer;
  logic [FP_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, mul_out;
  logic [3:0]      pick;
  logic [2:0]      g;
  always_comb begin
    pick       = rr_pick(8'(req_valid), 3'(ptr_q), NREQ);
    g          = pick[2:0];
    req_ready  = (pick[3] && s1_adv && !rst) ? NREQ'(1) << g : '0;
    xfer       = |(req_valid & req_ready);
    ptr_d      = xfer ? ((g == 3'(NREQ - 1)) ? '0 : IDW'(g + 3'd1)) : ptr_q;
    s1_valid_d = s1_adv ? xfer : s1_valid_q;
    s1_a_d     = xfer ? req_a[FP_W*g +: FP_W] : s1_a_q;
    s1_b_d     = xfer ? req_b[FP_W*g +: FP_W] : s1_b_q;
    s1_id_d    = xfer ? IDW'(g) : s1_id_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
    end
  end
  mul_fp_single u_mul (.a(s1_a_q), .b(s1_b_q), .out(mul_out));
`ifdef FP_MUL_ARB_OUTREG_EN
  logic            s2_valid_q, s2_valid_d, s2_load;
  logic [FP_W-1:0] s2_data_q, s2_data_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  assign s2_load    = !s2_valid_q || rsp_ready;
  assign s1_adv     = s2_load;
  assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  assign s2_data_d  = s2_load ? mul_out : s2_data_q;
  assign s2_id_d    = s2_load ? s1_id_q : s2_id_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
    end
  end
  assign rsp_valid = s2_valid_q;
  assign rsp_data  = s2_data_q;
  assign rsp_id    = s2_id_q;
  assign busy      = s1_valid_q || s2_valid_q;
`else
  assign s1_adv    = rsp_ready || !s1_valid_q;
  assign rsp_valid = s1_valid_q;
  assign rsp_data  = mul_out;
  assign rsp_id    = s1_id_q;
  assign busy      = s1_valid_q;
`endif
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter that shares one single-precision floating-point multiplier (`mul_fp_single`) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter registers the granted pair into a pipeline stage and returns the product on a single tagged response port with backpressure. It sits between the integer/control units that need FP multiplies and the one multiplier instance in the floating point module.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, $clog2(NREQ) (minimum 1): width of the requester tag.
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- req_valid  in  NREQ: bit i means requester i holds an operand pair.
- req_a  in  32*NREQ: operand A, slice [32i+31:32i] belongs to requester i.
- req_b  in  32*NREQ: operand B, same packing as req_a.
- req_ready  out  NREQ: one-hot grant; a pair transfers when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1: product available.
- rsp_data  out  32: IEEE-754 single-precision product.
- rsp_id  out  IDW: index of the requester that issued the pair.
- rsp_ready  in  1: consumer accepts the response.
- busy  out  1: any pipeline stage holds a valid entry.

## Operation
- Round-robin pointer `ptr` (IDW bits), reset 0.
  - Grant goes to the first i with req_valid[i], searching ptr, ptr+1, … NREQ-1, 0, … (wraps modulo NREQ).
  - On an accepted transfer from requester g, ptr <= (g+1) mod NREQ. The pointer does not change on cycles with no transfer.
- req_ready is combinational from req_valid, ptr and the pipeline state. It is asserted only when stage S1 can load: S1 is empty, or S1 advances in the same cycle. At most one bit is high. It is all zeros during reset.
- Stage S1 registers s1_valid, s1_a, s1_b and s1_id. It loads on transfer. It holds while downstream is stalled.
- The multiplier is driven combinationally from s1_a and s1_b.
  - Arithmetic is exactly that of mul_fp_single: sign XOR, biased exponent sum minus 127, 24x24-bit mantissa product, normalised by its mantissa stage.
  - If either operand equals 32'h0, the result is 0.
  - The arbiter adds no rounding, NaN or Inf handling.
- Without FP_MUL_ARB_OUTREG_EN, the response is S1 plus the multiplier output:
  - rsp_valid = s1_valid.
  - S1 advances when rsp_ready is high or S1 is empty.
- With FP_MUL_ARB_OUTREG_EN, see Configuration.
- busy = OR of all stage valid bits.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, busy=0, ptr=0, all stage registers 0.

## Timing
- Latency from transfer (edge N) to rsp_valid:
  - Without the macro: 1 cycle (high after edge N).
  - With the macro: 2 cycles.
- Throughput is one product per cycle while rsp_ready stays high.
- Backpressure:
  - With rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id are held stable.
  - No new transfer occurs while every stage is full.
- Simultaneous load and drain of S1 in one cycle is allowed and loses no bubble.
- Reset mid-operation:
  - In-flight products are discarded.
  - Pending requesters must re-present their pair; req_valid persists, so they are granted again after reset.
- A requester may drop req_valid without a transfer. The arbiter keeps no per-requester state.

## Configuration
- FP_MUL_ARB_OUTREG_EN defined:
  - Adds output stage S2 (s2_valid, s2_data, s2_id) that registers the multiplier output.
  - rsp_* come from S2.
  - S2 loads when it is empty or rsp_ready is high. S1 advances when S2 can load.
  - Latency is 2, which shortens the critical path through the multiplier.
- Undefined: S2 is absent and latency is 1, as described in Operation.

## Structure
- Package fp_mul_arb_pkg holds:
  - FP_W=32, EXP_BIAS=8'd127, FP_ZERO=32'h0.
  - The localparam rule for IDW.
  - A function rr_pick(valid, ptr) returning {found, index}.
- One sub-module: an instance of the existing mul_fp_single (a, b, out), unmodified.
- Arbitration, pipeline registers and the handshake stay in fp_mul_arbiter.

## Test plan
- Single request: req0 sends a=32'h40000000, b=32'h40400000 with rsp_ready=1. Expect rsp_data=32'h40C00000 and rsp_id=0 after 1 cycle (2 with the macro). busy then returns to 0.
- Contention: all four req_valid held high with distinct pairs. Grants occur in order 0,1,2,3,0. rsp_id follows the same order. For req2 a=32'hC0000000, b=32'h40400000, expect rsp_data=32'hC0C00000.
- Backpressure: rsp_ready=0 for 5 cycles with req1 sending 32'h3FC00000 x 32'h3FC00000. Expect rsp_valid held with rsp_data=32'h40100000 stable, and req_ready all 0 once the stages are full. No loss or duplication after rsp_ready=1.
- Zero operand: a=32'h0, b=32'h40400000. Expect rsp_data=32'h00000000.
- Pointer wrap: last grant to req3, then req3 and req0 both valid. Grant goes to req0.
- Reset mid-operation: assert rst while an entry is in S1. Outputs go to 0 immediately (asynchronous). After release, the first grant goes to the lowest valid index starting from ptr=0.
